// File: rtl/mem_stage_vlat.sv
// rtl/mem_stage_vlat.sv - MEM pipeline stage with variable-latency data-memory responses
module mem_stage_vlat #(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int RF_ADDR_W = 5,
   parameter int CANCEL_W  = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 ws_allowin,
   output logic                 ms_allowin,
   input  logic                 es_to_ms_valid,
   input  logic [PC_W-1:0]      es_pc,
   input  logic [DATA_W-1:0]    es_alu_result,
   input  logic [RF_ADDR_W-1:0] es_dest,
   input  logic                 es_gr_we,
   input  logic                 es_res_from_mem,
   input  logic [2:0]           es_mem_op,
   input  logic                 es_req_sent,
   input  logic                 flush,
   input  logic                 es_killed_inflight,
   input  logic                 data_sram_data_ok,
   input  logic [DATA_W-1:0]    data_sram_rdata,
   output logic                 ms_to_ws_valid,
   output logic [PC_W-1:0]      ms_pc,
   output logic [DATA_W-1:0]    ms_final_result,
   output logic [RF_ADDR_W-1:0] ms_dest,
   output logic                 ms_gr_we,
   output logic                 ms_fwd_blocked
);

   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int CNT_EXT_W = CANCEL_W + 2;
   localparam logic [CNT_EXT_W-1:0] CNT_MAX = CNT_EXT_W'((1 << CANCEL_W) - 1);

   logic                 ms_valid;
   logic [DATA_W-1:0]    alu_result_q;
   logic                 res_from_mem_q;
   logic [2:0]           mem_op_q;
   logic                 req_sent_q;
   logic [CANCEL_W-1:0]  cancel_cnt;
   logic                 data_got;
   logic [DATA_W-1:0]    rdata_buf;

   logic                 accept;
   logic                 handoff;
   logic                 cancel_drop;
   logic                 own_data_ok;
   logic                 wait_data;
   logic                 inc_wait;
   logic                 inc_kill;
   logic [CNT_EXT_W-1:0] cnt_sum;
   logic [CANCEL_W-1:0]  cnt_next;
   logic [DATA_W-1:0]    raw;
   logic [DATA_W-1:0]    shifted;
   logic [DATA_W-1:0]    extracted;

   assign cancel_drop = data_sram_data_ok && (cancel_cnt != '0);
   assign own_data_ok = data_sram_data_ok && (cancel_cnt == '0)
                        && ms_valid && req_sent_q && !data_got;
   assign wait_data   = ms_valid && req_sent_q && !data_got
                        && !(data_sram_data_ok && (cancel_cnt == '0));

   assign ms_allowin     = !ms_valid || (!wait_data && ws_allowin);
   assign ms_to_ws_valid = ms_valid && !wait_data && !flush;
   assign ms_fwd_blocked = ms_valid && res_from_mem_q && wait_data;

   assign accept  = es_to_ms_valid && ms_allowin && !flush;
   assign handoff = ms_to_ws_valid && ws_allowin;

   // A flush on an instruction that already got its data owes nothing; only a real wait does.
   assign inc_wait = flush && wait_data;
   assign inc_kill = es_killed_inflight;
   assign cnt_sum  = CNT_EXT_W'(cancel_cnt) + CNT_EXT_W'(inc_wait)
                     + CNT_EXT_W'(inc_kill) - CNT_EXT_W'(cancel_drop);
   assign cnt_next = (cnt_sum >= CNT_MAX) ? CNT_MAX[CANCEL_W-1:0] : cnt_sum[CANCEL_W-1:0];

   assign raw     = data_got ? rdata_buf : data_sram_rdata;
   assign shifted = raw >> {alu_result_q[OFF_W-1:0], 3'b000};

   // Sub-word extraction and sign/zero extension of the aligned load data.
   always_comb begin
      extracted = raw;
      case (mem_op_q)
         3'b000: begin
            extracted = {DATA_W{shifted[7]}};
            extracted[7:0] = shifted[7:0];
         end
         3'b001: begin
            extracted = {DATA_W{shifted[15]}};
            extracted[15:0] = shifted[15:0];
         end
         3'b010: begin
            extracted = {DATA_W{shifted[31]}};
            extracted[31:0] = shifted[31:0];
         end
         3'b011: begin
            if (DATA_W == 64) begin
               extracted = raw;
            end else begin
               extracted = {DATA_W{shifted[31]}};
               extracted[31:0] = shifted[31:0];
            end
         end
         3'b100: begin
            extracted = '0;
            extracted[7:0] = shifted[7:0];
         end
         3'b101: begin
            extracted = '0;
            extracted[15:0] = shifted[15:0];
         end
         3'b110: begin
            extracted = '0;
            extracted[31:0] = shifted[31:0];
         end
         default: extracted = raw;
      endcase
   end

   assign ms_final_result = res_from_mem_q ? extracted : alu_result_q;

   // Instruction slot: latch EX fields on accept, release on handoff, kill on flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid       <= 1'b0;
         ms_pc          <= '0;
         alu_result_q   <= '0;
         ms_dest        <= '0;
         ms_gr_we       <= 1'b0;
         res_from_mem_q <= 1'b0;
         mem_op_q       <= '0;
         req_sent_q     <= 1'b0;
      end else begin
         if (flush) begin
            ms_valid <= 1'b0;
         end else if (accept) begin
            ms_valid <= 1'b1;
         end else if (handoff) begin
            ms_valid <= 1'b0;
         end
         if (accept) begin
            ms_pc          <= es_pc;
            alu_result_q   <= es_alu_result;
            ms_dest        <= es_dest;
            ms_gr_we       <= es_gr_we;
            res_from_mem_q <= es_res_from_mem;
            mem_op_q       <= es_mem_op;
            req_sent_q     <= es_req_sent;
         end
      end
   end

   // Response bookkeeping: hold our data while WB stalls, count responses owed to killed requests.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cancel_cnt <= '0;
         data_got   <= 1'b0;
         rdata_buf  <= '0;
      end else begin
         cancel_cnt <= cnt_next;
         if (accept || flush) begin
            data_got <= 1'b0;
         end else if (own_data_ok && !handoff) begin
            data_got  <= 1'b1;
            rdata_buf <= data_sram_rdata;
         end
      end
   end

   // The cancel counter must never reach its ceiling; doing so would lose track of stale responses.
   always @(posedge clk) begin
      if (resetn) begin
         assert (cnt_sum < CNT_MAX);
      end
   end

endmodule

// File: tb/tb_mem_stage_vlat.sv
// tb/tb_mem_stage_vlat.sv - self-checking bench for mem_stage_vlat
module tb_mem_stage_vlat;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ws_allowin;
   logic        es_to_ms_valid;
   logic [31:0] es_pc;
   logic [31:0] es_alu_result;
   logic [63:0] es_alu_result64;
   logic [4:0]  es_dest;
   logic        es_gr_we;
   logic        es_res_from_mem;
   logic [2:0]  es_mem_op;
   logic        es_req_sent;
   logic        flush;
   logic        es_killed_inflight;
   logic        data_ok;
   logic [31:0] rdata;
   logic [63:0] rdata64;

   logic        ms_allowin, ms_to_ws_valid, ms_gr_we, ms_fwd_blocked;
   logic [31:0] ms_pc, ms_final_result;
   logic [4:0]  ms_dest;
   logic        ms_allowin64, ms_to_ws_valid64, ms_gr_we64, ms_fwd_blocked64;
   logic [31:0] ms_pc64;
   logic [63:0] ms_final_result64;
   logic [4:0]  ms_dest64;

   int checks = 0;
   int failures = 0;

   mem_stage_vlat dut32 (
      .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
      .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_alu_result(es_alu_result),
      .es_dest(es_dest), .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem),
      .es_mem_op(es_mem_op), .es_req_sent(es_req_sent), .flush(flush),
      .es_killed_inflight(es_killed_inflight), .data_sram_data_ok(data_ok),
      .data_sram_rdata(rdata), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
      .ms_final_result(ms_final_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
      .ms_fwd_blocked(ms_fwd_blocked)
   );

   mem_stage_vlat #(.DATA_W(64)) dut64 (
      .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin64),
      .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_alu_result(es_alu_result64),
      .es_dest(es_dest), .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem),
      .es_mem_op(es_mem_op), .es_req_sent(es_req_sent), .flush(flush),
      .es_killed_inflight(es_killed_inflight), .data_sram_data_ok(data_ok),
      .data_sram_rdata(rdata64), .ms_to_ws_valid(ms_to_ws_valid64), .ms_pc(ms_pc64),
      .ms_final_result(ms_final_result64), .ms_dest(ms_dest64), .ms_gr_we(ms_gr_we64),
      .ms_fwd_blocked(ms_fwd_blocked64)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_load;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] rd;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [63:0] addr;
      logic [63:0] rd;
      logic [63:0] exp;
   } vec64_t;

   vec_t   vecs[11];
   vec64_t vecs64[4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic start_load(input logic [2:0] op, input logic [31:0] addr, input logic [63:0] addr64);
      es_to_ms_valid  = 1'b1;
      es_res_from_mem = 1'b1;
      es_req_sent     = 1'b1;
      es_gr_we        = 1'b1;
      es_mem_op       = op;
      es_alu_result   = addr;
      es_alu_result64 = addr64;
      settle();
      chk("accept_allowin", ms_allowin, 1);
      tick();
      es_to_ms_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_allowin"}, ms_allowin, 1);
      chk({tag, "_valid"}, ms_to_ws_valid, 0);
      chk({tag, "_result"}, ms_final_result, 0);
      chk({tag, "_pc"}, ms_pc, 0);
      chk({tag, "_dest"}, ms_dest, 0);
      chk({tag, "_gr_we"}, ms_gr_we, 0);
      chk({tag, "_fwd"}, ms_fwd_blocked, 0);
      chk({tag, "_allowin64"}, ms_allowin64, 1);
      chk({tag, "_valid64"}, ms_to_ws_valid64, 0);
      chk({tag, "_result64"}, ms_final_result64, 0);
      chk({tag, "_fwd64"}, ms_fwd_blocked64, 0);
   endtask

   initial begin
      logic [31:0] exp_pc;

      vecs[0]  = '{1'b0, 3'b010, 32'h0000_1234, 32'h0,         32'h0000_1234};
      vecs[1]  = '{1'b1, 3'b000, 32'h1000_0001, 32'h0000_8000, 32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 3'b100, 32'h1000_0001, 32'h0000_8000, 32'h0000_0080};
      vecs[3]  = '{1'b1, 3'b001, 32'h1000_0002, 32'hBEEF_0000, 32'hFFFF_BEEF};
      vecs[4]  = '{1'b1, 3'b101, 32'h1000_0002, 32'hBEEF_0000, 32'h0000_BEEF};
      vecs[5]  = '{1'b1, 3'b010, 32'h1000_0000, 32'h8765_4321, 32'h8765_4321};
      vecs[6]  = '{1'b1, 3'b000, 32'h1000_0003, 32'h7F00_0000, 32'h0000_007F};
      vecs[7]  = '{1'b1, 3'b001, 32'h1000_0000, 32'h0001_7FFF, 32'h0000_7FFF};
      vecs[8]  = '{1'b1, 3'b011, 32'h1000_0000, 32'h8000_0000, 32'h8000_0000};
      vecs[9]  = '{1'b1, 3'b110, 32'h1000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[10] = '{1'b1, 3'b100, 32'h1000_0000, 32'h1234_56FF, 32'h0000_00FF};

      vecs64[0] = '{3'b110, 64'h0000_0000_2000_0004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001};
      vecs64[1] = '{3'b010, 64'h0000_0000_2000_0004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
      vecs64[2] = '{3'b011, 64'h0000_0000_2000_0000, 64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000};
      vecs64[3] = '{3'b000, 64'h0000_0000_2000_0007, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FF80};

      resetn = 1'b0;
      ws_allowin = 1'b1;
      es_to_ms_valid = 1'b0;
      es_pc = '0;
      es_alu_result = '0;
      es_alu_result64 = '0;
      es_dest = '0;
      es_gr_we = 1'b0;
      es_res_from_mem = 1'b0;
      es_mem_op = '0;
      es_req_sent = 1'b0;
      flush = 1'b0;
      es_killed_inflight = 1'b0;
      data_ok = 1'b0;
      rdata = '0;
      rdata64 = '0;

      #12;
      check_reset_outputs("reset");
      resetn = 1'b1;
      tick();

      // Table: accept, optional one-cycle response, handoff.
      for (int i = 0; i < 11; i++) begin
         exp_pc = 32'h1c00_0000 + 32'(i * 4);
         es_pc = exp_pc;
         es_dest = 5'(i + 1);
         es_gr_we = 1'b1;
         es_res_from_mem = vecs[i].is_load;
         es_req_sent = vecs[i].is_load;
         es_mem_op = vecs[i].op;
         es_alu_result = vecs[i].addr;
         es_to_ms_valid = 1'b1;
         settle();
         chk("vec_allowin", ms_allowin, 1);
         tick();
         es_to_ms_valid = 1'b0;
         if (vecs[i].is_load) begin
            settle();
            chk("vec_fwd_blocked", ms_fwd_blocked, 1);
            chk("vec_wait_valid", ms_to_ws_valid, 0);
            data_ok = 1'b1;
            rdata = vecs[i].rd;
         end
         settle();
         chk("vec_valid", ms_to_ws_valid, 1);
         chk("vec_result", ms_final_result, vecs[i].exp);
         chk("vec_pc", ms_pc, exp_pc);
         chk("vec_dest", ms_dest, 5'(i + 1));
         tick();
         data_ok = 1'b0;
         settle();
         chk("vec_drained", ms_to_ws_valid, 0);
      end

      // LB / LBU with three waiting cycles before the response.
      for (int r = 0; r < 2; r++) begin
         start_load((r == 0) ? 3'b000 : 3'b100, 32'h1000_0001, 64'h0);
         for (int k = 0; k < 3; k++) begin
            settle();
            chk("lat_fwd_blocked", ms_fwd_blocked, 1);
            chk("lat_valid", ms_to_ws_valid, 0);
            chk("lat_allowin", ms_allowin, 0);
            tick();
         end
         data_ok = 1'b1;
         rdata = 32'h0000_8000;
         settle();
         chk("lat_data_valid", ms_to_ws_valid, 1);
         chk("lat_fwd_clear", ms_fwd_blocked, 0);
         chk("lat_result", ms_final_result, (r == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         tick();
         data_ok = 1'b0;
      end

      // WB stall: response arrives while WB is blocked and must be held.
      start_load(3'b101, 32'h2000_0002, 64'h0);
      ws_allowin = 1'b0;
      data_ok = 1'b1;
      rdata = 32'hBEEF_0000;
      settle();
      chk("stall_bypass_result", ms_final_result, 32'h0000_BEEF);
      chk("stall_valid", ms_to_ws_valid, 1);
      chk("stall_allowin", ms_allowin, 0);
      tick();
      data_ok = 1'b0;
      rdata = 32'h1111_1111;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("stall_hold_result", ms_final_result, 32'h0000_BEEF);
         chk("stall_hold_allowin", ms_allowin, 0);
         chk("stall_hold_valid", ms_to_ws_valid, 1);
         chk("stall_hold_fwd", ms_fwd_blocked, 0);
         tick();
      end
      ws_allowin = 1'b1;
      settle();
      chk("stall_release_allowin", ms_allowin, 1);
      chk("stall_release_result", ms_final_result, 32'h0000_BEEF);
      tick();
      settle();
      chk("stall_drained", ms_to_ws_valid, 0);

      // Flush while waiting with an in-flight EX request also killed.
      start_load(3'b010, 32'h3000_0000, 64'h0);
      flush = 1'b1;
      es_killed_inflight = 1'b1;
      settle();
      chk("flush_valid", ms_to_ws_valid, 0);
      tick();
      flush = 1'b0;
      es_killed_inflight = 1'b0;
      settle();
      chk("flush_cancel_cnt", dut32.cancel_cnt, 2);
      chk("flush_cleared", ms_to_ws_valid, 0);
      start_load(3'b010, 32'h3000_0004, 64'h0);
      data_ok = 1'b1;
      rdata = 32'h1111_1111;
      settle();
      chk("drop1_valid", ms_to_ws_valid, 0);
      chk("drop1_fwd", ms_fwd_blocked, 1);
      tick();
      rdata = 32'h2222_2222;
      settle();
      chk("drop1_cnt", dut32.cancel_cnt, 1);
      chk("drop2_valid", ms_to_ws_valid, 0);
      tick();
      rdata = 32'hCAFE_F00D;
      settle();
      chk("drop2_cnt", dut32.cancel_cnt, 0);
      chk("deliver_valid", ms_to_ws_valid, 1);
      chk("deliver_result", ms_final_result, 32'hCAFE_F00D);
      tick();
      data_ok = 1'b0;

      // Flush in the same cycle as MEM's own response.
      start_load(3'b010, 32'h3000_0008, 64'h0);
      flush = 1'b1;
      data_ok = 1'b1;
      rdata = 32'h5555_5555;
      settle();
      chk("same_flush_valid", ms_to_ws_valid, 0);
      tick();
      flush = 1'b0;
      data_ok = 1'b0;
      settle();
      chk("same_flush_cnt", dut32.cancel_cnt, 0);
      chk("same_flush_cleared", ms_to_ws_valid, 0);
      chk("same_flush_allowin", ms_allowin, 1);

      // 64-bit data path.
      for (int i = 0; i < 4; i++) begin
         start_load(vecs64[i].op, 32'h0, vecs64[i].addr);
         data_ok = 1'b1;
         rdata64 = vecs64[i].rd;
         settle();
         chk("w64_valid", ms_to_ws_valid64, 1);
         chk("w64_result", ms_final_result64, vecs64[i].exp);
         tick();
         data_ok = 1'b0;
      end

      // Reset while a load waits: everything drops at once, the late response is ignored.
      start_load(3'b010, 32'h4000_0000, 64'h0000_0000_4000_0000);
      settle();
      chk("rst_wait_fwd", ms_fwd_blocked, 1);
      resetn = 1'b0;
      #1;
      check_reset_outputs("midreset");
      resetn = 1'b1;
      tick();
      data_ok = 1'b1;
      rdata = 32'h7777_7777;
      settle();
      chk("post_reset_valid", ms_to_ws_valid, 0);
      chk("post_reset_fwd", ms_fwd_blocked, 0);
      tick();
      data_ok = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
